// File: rtl/custom_acc_feeder.sv
// custom_acc_feeder
//   Operand sequencer in front of custom_acc. A start command clears the
//   accumulator, streams len consecutive 32-bit words out of a synchronous
//   memory, splits each word into four bytes for custom_acc and pulses done
//   once the accumulator holds the final sum.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      command strobe, only honoured in IDLE
//   base_addr  first word address, captured with start
//   len        number of words, captured with start (0 = immediate done)
//   mem_rd_en  memory read request
//   mem_addr   memory word address, wraps modulo 2**ADDR_W
//   mem_rdata  memory read data, valid the cycle after mem_rd_en
//   acc_rst    clear strobe for custom_acc
//   acc_en     enable for custom_acc
//   acc_in_1..acc_in_4  bytes 0..3 of the returned word (0 when acc_en=0)
//   busy       command in progress
//   done       one-cycle completion pulse
//
// Every output is a register; nothing combinational runs from an input to an
// output.
module custom_acc_feeder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              acc_rst,
    output logic              acc_en,
    output logic [7:0]        acc_in_1,
    output logic [7:0]        acc_in_2,
    output logic [7:0]        acc_in_3,
    output logic [7:0]        acc_in_4,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt;    // reads issued so far in this command
    logic              drain_cnt;
    logic              rd_pend;   // mem_rdata carries a requested word this cycle

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            base_q    <= '0;
            len_q     <= '0;
            rd_cnt    <= '0;
            drain_cnt <= 1'b0;
            rd_pend   <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            acc_rst   <= 1'b0;
            acc_en    <= 1'b0;
            acc_in_1  <= '0;
            acc_in_2  <= '0;
            acc_in_3  <= '0;
            acc_in_4  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Two-stage data path: request -> memory latency -> registered bytes.
            rd_pend <= mem_rd_en;
            acc_en  <= rd_pend;
            if (rd_pend) begin
                acc_in_1 <= mem_rdata[7:0];
                acc_in_2 <= mem_rdata[15:8];
                acc_in_3 <= mem_rdata[23:16];
                acc_in_4 <= mem_rdata[31:24];
            end else begin
                acc_in_1 <= '0;
                acc_in_2 <= '0;
                acc_in_3 <= '0;
                acc_in_4 <= '0;
            end

            acc_rst   <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (len != '0) begin
                            base_q  <= base_addr;
                            len_q   <= len;
                            acc_rst <= 1'b1;
                            busy    <= 1'b1;
                            state   <= StClear;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StClear: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= base_q;
                    rd_cnt    <= LEN_W'(1);
                    state     <= StRead;
                end
                StRead: begin
                    if (rd_cnt == len_q) begin
                        mem_addr  <= '0;
                        drain_cnt <= 1'b0;
                        state     <= StDrain;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        rd_cnt    <= rd_cnt + LEN_W'(1);
                    end
                end
                StDrain: begin
                    if (drain_cnt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                StDone: begin
                    rd_cnt <= '0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
